// File: rtl/riscv_test_monitor.sv
// Test-completion monitor: watches per-hart store channels for tohost writes and
// reports PASS / FAIL / TIMEOUT along with the cycle count spent running.

module riscv_test_monitor_hart #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000
) (
   input  logic              vld,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   output logic              pass_hit,
   output logic              fail_hit
);
   logic tohost;

   // Even data values are not completion codes and are ignored.
   always_comb begin
      tohost   = vld && (addr == TOHOST_ADDR);
      pass_hit = tohost && (data == DATA_W'(1));
      fail_hit = tohost && data[0] && (data != DATA_W'(1));
   end
endmodule

module riscv_test_monitor #(
   parameter int                NUM_HARTS   = 1,
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000,
   parameter int                TIMEOUT     = 5000,
   parameter int                CNT_W       = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_HARTS-1:0]        st_valid,
   input  logic [NUM_HARTS*ADDR_W-1:0] st_addr,
   input  logic [NUM_HARTS*DATA_W-1:0] st_data,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        timeout,
   output logic [2:0]                  fail_hart,
   output logic [DATA_W-2:0]           fail_code,
   output logic [NUM_HARTS-1:0]        pass_mask,
   output logic [CNT_W-1:0]            cycles
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_PASS = 3'd2;
   localparam logic [2:0] S_FAIL = 3'd3;
   localparam logic [2:0] S_TO   = 3'd4;

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);

   logic [2:0]           state_q,     state_d;
   logic [CNT_W-1:0]     cycles_q,    cycles_d;
   logic [NUM_HARTS-1:0] pass_mask_q, pass_mask_d;
   logic [2:0]           fail_hart_q, fail_hart_d;
   logic [DATA_W-2:0]    fail_code_q, fail_code_d;

   logic [NUM_HARTS-1:0] pass_hits, fail_hits;
   logic [NUM_HARTS-1:0] mask_nxt;
   logic                 fail_any;
   logic [2:0]           sel_hart;
   logic [DATA_W-2:0]    sel_code;
   logic [CNT_W-1:0]     cyc_inc;

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      riscv_test_monitor_hart #(
         .ADDR_W      (ADDR_W),
         .DATA_W      (DATA_W),
         .TOHOST_ADDR (TOHOST_ADDR)
      ) u_hart (
         .vld      (st_valid[h]),
         .addr     (st_addr[h*ADDR_W +: ADDR_W]),
         .data     (st_data[h*DATA_W +: DATA_W]),
         .pass_hit (pass_hits[h]),
         .fail_hit (fail_hits[h])
      );
   end

   // Scan from the top so the lowest failing hart is the one left selected.
   always_comb begin
      fail_any = |fail_hits;
      sel_hart = '0;
      sel_code = '0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (fail_hits[h]) begin
            sel_hart = 3'(h);
            sel_code = st_data[h*DATA_W + 1 +: DATA_W - 1];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cycles_d    = cycles_q;
      pass_mask_d = pass_mask_q;
      fail_hart_d = fail_hart_q;
      fail_code_d = fail_code_q;
      cyc_inc     = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
      mask_nxt    = pass_mask_q | pass_hits;
      case (state_q)
         S_IDLE, S_PASS, S_FAIL, S_TO: begin
            if (start) begin
               state_d     = S_RUN;
               cycles_d    = '0;
               pass_mask_d = '0;
               fail_hart_d = '0;
               fail_code_d = '0;
            end
         end
         S_RUN: begin
            // The deciding cycle is counted, so cycles equals RUN cycles on exit.
            cycles_d    = cyc_inc;
            pass_mask_d = mask_nxt;
            if (fail_any) begin
               state_d     = S_FAIL;
               fail_hart_d = sel_hart;
               fail_code_d = sel_code;
            end else if (&mask_nxt) begin
               state_d = S_PASS;
            end else if (cycles_q == TO_LIM) begin
               state_d = S_TO;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cycles_q    <= '0;
         pass_mask_q <= '0;
         fail_hart_q <= '0;
         fail_code_q <= '0;
      end else begin
         state_q     <= state_d;
         cycles_q    <= cycles_d;
         pass_mask_q <= pass_mask_d;
         fail_hart_q <= fail_hart_d;
         fail_code_q <= fail_code_d;
      end
   end

   always_comb begin
      busy      = (state_q == S_RUN);
      pass      = (state_q == S_PASS);
      timeout   = (state_q == S_TO);
      done      = pass || timeout || (state_q == S_FAIL);
      fail_hart = fail_hart_q;
      fail_code = fail_code_q;
      pass_mask = pass_mask_q;
      cycles    = cycles_q;
   end
endmodule
